// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss-fill controller.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

    localparam int BLOCK_OFFSET_W = 4;  // byte offset bits within a 16-byte block
    localparam int WORD_IDX_W     = 3;  // word index bits within a block

    localparam logic FILL_SEL_I = 1'b0;
    localparam logic FILL_SEL_D = 1'b1;

endpackage

// File: rtl/fill_word_counter.sv
// Loadable wrap-around word index counter. The tally counts increments since
// the last load, so "done" means every word of the block has been stepped
// through no matter which word the walk started on.
module fill_word_counter
    import cache_pkg::*;
#(
    parameter int W = WORD_IDX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic [W:0]   tally,
    output logic         done
);

    assign done = tally[W];

    // Index wraps naturally at 2**W; tally freezes once all words are counted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            tally <= '0;
        end else if (load) begin
            cnt   <= load_val;
            tally <= '0;
        end else if (en && !done) begin
            cnt   <= cnt + 1'b1;
            tally <= tally + 1'b1;
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Miss-service controller: fetches a whole block from pipelined main memory
// into the I- or D-cache and stalls the requester until the tag is written.
// Optional macro CRITICAL_WORD_FIRST_EN starts the block walk at the missed
// word and adds the crit_word_valid output.
module cache_fill_ctrl
    import cache_pkg::*;
#(
    parameter int MEM_LATENCY     = 4,
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_miss,
    input  logic [ADDR_W-1:0] i_miss_addr,
    input  logic              d_miss,
    input  logic [ADDR_W-1:0] d_miss_addr,
    output logic              i_stall,
    output logic              d_stall,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_data_valid,
    input  logic [15:0]       mem_data,
    output logic              fill_we,
    output logic              fill_sel_d,
    output logic [ADDR_W-1:0] fill_addr,
    output logic [15:0]       fill_data,
    output logic              tag_we,
    output logic              i_fill_done,
`ifdef CRITICAL_WORD_FIRST_EN
    output logic              d_fill_done,
    output logic              crit_word_valid
`else
    output logic              d_fill_done
`endif
);

    localparam int BLK_W = ADDR_W - BLOCK_OFFSET_W;
    localparam logic [WORD_IDX_W:0] LAST_WORD = (WORD_IDX_W+1)'(WORDS_PER_BLOCK - 1);

    // Reject configurations the fixed-width counters cannot represent.
    if (WORDS_PER_BLOCK != (1 << WORD_IDX_W) || MEM_LATENCY < 1) begin : g_bad_cfg
        $error("cache_fill_ctrl: unsupported WORDS_PER_BLOCK or MEM_LATENCY");
    end

    fill_state_t             state, state_nxt;
    logic                    sel;
    logic [BLK_W-1:0]        block;
    logic                    take;
    logic                    take_sel;
    logic [ADDR_W-1:0]       take_addr;
    logic [WORD_IDX_W-1:0]   load_val;
    logic [WORD_IDX_W-1:0]   iss_cnt, rcv_cnt;
    logic [WORD_IDX_W:0]     iss_tally, rcv_tally;
    logic                    iss_done, rcv_done;
    logic                    busy;
    logic                    unused_bits;

    // D wins a simultaneous miss; the pending I miss is picked up on return to IDLE.
    assign take_sel  = d_miss ? FILL_SEL_D : FILL_SEL_I;
    assign take_addr = d_miss ? d_miss_addr : i_miss_addr;

`ifdef CRITICAL_WORD_FIRST_EN
    assign load_val = take_addr[BLOCK_OFFSET_W-1:1];
`else
    assign load_val = '0;
`endif

    fill_word_counter #(.W(WORD_IDX_W)) u_issue (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .load_val (load_val),
        .en       (mem_en),
        .cnt      (iss_cnt),
        .tally    (iss_tally),
        .done     (iss_done)
    );

    fill_word_counter #(.W(WORD_IDX_W)) u_recv (
        .clk      (clk),
        .rst      (rst),
        .load     (take),
        .load_val (load_val),
        .en       (fill_we),
        .cnt      (rcv_cnt),
        .tally    (rcv_tally),
        .done     (rcv_done)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the block being served and which cache it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel   <= FILL_SEL_I;
            block <= '0;
        end else if (take) begin
            sel   <= take_sel;
            block <= take_addr[ADDR_W-1:BLOCK_OFFSET_W];
        end
    end

    // Next state and per-cycle strobes; returns outside FILL are dropped.
    always_comb begin
        state_nxt   = state;
        take        = 1'b0;
        mem_en      = 1'b0;
        fill_we     = 1'b0;
        tag_we      = 1'b0;
        i_fill_done = 1'b0;
        d_fill_done = 1'b0;
        case (state)
            IDLE: begin
                if (d_miss || i_miss) begin
                    take      = 1'b1;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                mem_en  = !iss_done;
                fill_we = mem_data_valid;
                if (mem_data_valid && rcv_tally == LAST_WORD) begin
                    tag_we    = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                i_fill_done = (sel == FILL_SEL_I);
                d_fill_done = (sel == FILL_SEL_D);
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign i_stall    = i_miss | (busy & (sel == FILL_SEL_I));
    assign d_stall    = d_miss | (busy & (sel == FILL_SEL_D));
    assign fill_sel_d = sel;
    assign mem_addr   = {block, iss_cnt, 1'b0};
    assign fill_addr  = {block, rcv_cnt, 1'b0};
    assign fill_data  = fill_we ? mem_data : 16'h0000;

`ifdef CRITICAL_WORD_FIRST_EN
    // First word written is always the one the pipeline missed on.
    assign crit_word_valid = fill_we & (rcv_tally == '0);
`endif

    assign unused_bits = ^{i_miss_addr[BLOCK_OFFSET_W-1:0], d_miss_addr[BLOCK_OFFSET_W-1:0],
                           iss_tally[WORD_IDX_W-1:0], rcv_done};

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Self-checking bench for cache_fill_ctrl: a behavioural pipelined memory,
// scoreboard queues for issues/fills/done pulses, a vector table of misses,
// and directed sequences for reset, dropped misses and stray returns.
module tb_cache_fill_ctrl;

    localparam int MEM_LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_miss = 1'b0, d_miss = 1'b0;
    logic [15:0] i_miss_addr = '0, d_miss_addr = '0;
    logic        i_stall, d_stall, mem_en, fill_we, fill_sel_d, tag_we;
    logic        i_fill_done, d_fill_done;
    logic [15:0] mem_addr, fill_addr, fill_data, mem_data;
    logic        mem_data_valid;
    logic        force_valid = 1'b0;
`ifdef CRITICAL_WORD_FIRST_EN
    logic        crit_word_valid;
`endif

    always #5 clk = ~clk;

    cache_fill_ctrl #(.MEM_LATENCY(MEM_LAT), .WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .d_miss(d_miss), .d_miss_addr(d_miss_addr),
        .i_stall(i_stall), .d_stall(d_stall),
        .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_data_valid(mem_data_valid), .mem_data(mem_data),
        .fill_we(fill_we), .fill_sel_d(fill_sel_d), .fill_addr(fill_addr),
        .fill_data(fill_data), .tag_we(tag_we),
        .i_fill_done(i_fill_done),
`ifdef CRITICAL_WORD_FIRST_EN
        .d_fill_done(d_fill_done),
        .crit_word_valid(crit_word_valid)
`else
        .d_fill_done(d_fill_done)
`endif
    );

    function automatic logic [15:0] mdata(input logic [15:0] a);
        return a ^ 16'h5A3C;
    endfunction

    // Memory: a request seen at the end of cycle c returns data in cycle c+MEM_LAT-1.
    logic [MEM_LAT-2:0] pv = '0;
    logic [15:0]        pa [MEM_LAT-1];
    always @(posedge clk) begin
        pv[0] <= mem_en;
        pa[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT-1; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign mem_data_valid = pv[MEM_LAT-2] | force_valid;
    assign mem_data       = force_valid ? 16'hDEAD : mdata(pa[MEM_LAT-2]);

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard
    typedef struct {
        logic        sel;
        logic [15:0] addr;
        logic [15:0] data;
        logic        tag;
        logic        crit;
    } fexp_t;
    fexp_t       fill_q[$];
    logic [15:0] iss_q[$];
    logic        done_q[$];

    int nvec = 0, nerr = 0;
    int start_cyc = 0, rel;
    int first_iss, first_we, first_tag, done_rel;
    int we_cnt = 0, iss_n = 0, done_n = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic push_block(input logic sel, input logic [15:0] addr);
        logic [2:0] w, k;
        logic [15:0] a;
`ifdef CRITICAL_WORD_FIRST_EN
        w = addr[3:1];
`else
        w = 3'd0;
`endif
        for (int j = 0; j < 8; j++) begin
            k = w + 3'(j);
            a = {addr[15:4], k, 1'b0};
            iss_q.push_back(a);
            fill_q.push_back('{sel, a, mdata(a), (j == 7), (j == 0)});
        end
        done_q.push_back(sel);
    endtask

    // Monitor: compare every DUT event against the scoreboard, mid-cycle.
    fexp_t       fe;
    logic [15:0] ea;
    logic        ds;
    always @(negedge clk) begin
        if (!rst) begin
            rel = cyc - start_cyc + 1;
            if (i_miss) chk("i_stall while i_miss", i_stall, 1'b1);
            if (d_miss) chk("d_stall while d_miss", d_stall, 1'b1);
            if (mem_en) begin
                iss_n++;
                if (first_iss == 0) first_iss = rel;
                chk("mem_en expected", iss_q.size() != 0, 1'b1);
                if (iss_q.size() != 0) begin
                    ea = iss_q.pop_front();
                    chk("mem_addr", mem_addr, ea);
                end
            end
            if (fill_we) begin
                we_cnt++;
                if (first_we == 0) first_we = rel;
                chk("fill_we expected", fill_q.size() != 0, 1'b1);
                if (fill_q.size() != 0) begin
                    fe = fill_q.pop_front();
                    chk("fill_sel_d", fill_sel_d, fe.sel);
                    chk("fill_addr", fill_addr, fe.addr);
                    chk("fill_data", fill_data, fe.data);
                    chk("tag_we", tag_we, fe.tag);
                    if (tag_we && first_tag == 0) first_tag = rel;
`ifdef CRITICAL_WORD_FIRST_EN
                    chk("crit_word_valid", crit_word_valid, fe.crit);
`endif
                end
            end else if (tag_we) begin
                chk("tag_we needs fill_we", fill_we, 1'b1);
            end
            if (i_fill_done || d_fill_done) begin
                done_n++;
                done_rel = rel;
                chk("done expected", done_q.size() != 0, 1'b1);
                if (done_q.size() != 0) begin
                    ds = done_q.pop_front();
                    chk("done select", {d_fill_done, i_fill_done}, ds ? 2'b10 : 2'b01);
                end
            end
        end
    end

    task automatic chk_zero(input string nm);
        chk({nm, " ctrl"}, {mem_en, fill_we, tag_we, i_fill_done, d_fill_done, i_stall, d_stall}, 7'b0);
        chk({nm, " mem_addr"}, mem_addr, 16'h0);
        chk({nm, " fill_addr"}, fill_addr, 16'h0);
        chk({nm, " fill_data"}, fill_data, 16'h0);
        chk({nm, " fill_sel_d"}, fill_sel_d, 1'b0);
    endtask

    task automatic clear_stats();
        first_iss = 0; first_we = 0; first_tag = 0; done_rel = 0;
    endtask

    task automatic start_miss(input logic im, input logic [15:0] ia, input logic dm, input logic [15:0] da);
        @(posedge clk); #1;
        start_cyc   = cyc;
        i_miss      = im;
        i_miss_addr = ia;
        d_miss      = dm;
        d_miss_addr = da;
    endtask

    // Hold misses until their done pulse, as the caches do.
    task automatic wait_fills(input string nm);
        int n = 0;
        while ((i_miss || d_miss || done_q.size() != 0) && n < 80) begin
            @(posedge clk); #1;
            if (i_fill_done) i_miss = 1'b0;
            if (d_fill_done) d_miss = 1'b0;
            n++;
        end
        chk({nm, " completes in budget"}, n < 80, 1'b1);
    endtask

    typedef struct {
        logic        im;
        logic [15:0] ia;
        logic        dm;
        logic [15:0] da;
        int          done_rel;
    } vec_t;
    vec_t vt [6];

    initial begin
        vt[0] = '{1'b1, 16'h0046, 1'b0, 16'h0000, 13};
        vt[1] = '{1'b0, 16'h0000, 1'b1, 16'h1230, 13};
        vt[2] = '{1'b1, 16'h0200, 1'b1, 16'h1230, 26};
        vt[3] = '{1'b1, 16'hFFFE, 1'b0, 16'h0000, 13};
        vt[4] = '{1'b0, 16'h0000, 1'b1, 16'h00AC, 13};
        vt[5] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 13};

        clear_stats();
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        rst = 1'b0;
        @(posedge clk); #1 chk_zero("idle after reset");

        // Table of miss patterns
        foreach (vt[v]) begin
            clear_stats();
            if (vt[v].dm) push_block(1'b1, vt[v].da);
            if (vt[v].im) push_block(1'b0, vt[v].ia);
            start_miss(vt[v].im, vt[v].ia, vt[v].dm, vt[v].da);
            wait_fills("vector");
            chk("first mem_en cycle", first_iss, 2);
            chk("first fill_we cycle", first_we, 5);
            chk("first tag_we cycle", first_tag, 12);
            chk("last done cycle", done_rel, vt[v].done_rel);
            chk("stalls released", {i_stall, d_stall}, 2'b00);
            chk("scoreboard drained", iss_q.size() + fill_q.size(), 0);
        end

        // I miss withdrawn mid-fill: fill still completes and keeps stalling
        clear_stats();
        push_block(1'b0, 16'h0520);
        start_miss(1'b1, 16'h0520, 1'b0, 16'h0);
        repeat (5) @(posedge clk);
        #1 i_miss = 1'b0;
        @(negedge clk);
        chk("i_stall after miss drop", i_stall, 1'b1);
        wait_fills("dropped miss");
        chk("dropped miss done cycle", done_rel, 13);

        // Reset after three returned words aborts the fill
        clear_stats();
        push_block(1'b0, 16'h0300);
        start_miss(1'b1, 16'h0300, 1'b0, 16'h0);
        we_cnt = 0;
        for (int n = 0; n < 20 && we_cnt < 3; n++) begin
            @(posedge clk); #1;
        end
        chk("three words before reset", we_cnt, 3);
        rst = 1'b1;
        i_miss = 1'b0;
        #1 chk_zero("reset mid-fill");
        iss_q.delete(); fill_q.delete(); done_q.delete();
        we_cnt = 0; iss_n = 0; done_n = 0;
        @(posedge clk); #1 rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("fill_we after abort", we_cnt, 0);
        chk("mem_en after abort", iss_n, 0);
        chk("done after abort", done_n, 0);

        // Stray return while idle
        we_cnt = 0; iss_n = 0;
        @(posedge clk); #1 force_valid = 1'b1;
        @(posedge clk); @(posedge clk); #1 force_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("fill_we on stray valid", we_cnt, 0);
        chk("mem_en on stray valid", iss_n, 0);

        // Controller still serves a normal miss afterwards
        clear_stats();
        push_block(1'b0, 16'h0046);
        start_miss(1'b1, 16'h0046, 1'b0, 16'h0);
        wait_fills("after stray");
        chk("done cycle after stray", done_rel, 13);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/cache_fill_ctrl.md
Name: cache_fill_ctrl

Overview:
- Miss-service controller between the pipelined CPU's I-cache/D-cache and the 4-cycle pipelined main memory.
- On an I-fetch or D-access miss, fetches the 16-byte block (8 x 16-bit words), writes each word into the selected cache's data array, then writes the tag.
- Stalls the requesting side until the fill completes.
- Sits directly downstream of the fetch and memory stages.

Parameters:
- MEM_LATENCY, 4, cycles from request issue to returned data, mem_data_valid.
- WORDS_PER_BLOCK, 8, 16-bit words per cache block; must be a power of 2.
- ADDR_W, 16, byte-address width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- i_miss  input  1  I-cache miss; held high until i_fill_done.
- i_miss_addr  input  ADDR_W  byte address of the missing fetch.
- d_miss  input  1  D-cache miss; held high until d_fill_done.
- d_miss_addr  input  ADDR_W  byte address of the missing load/store.
- i_stall  output  1  freeze IF/PC while an I-miss is pending or in service.
- d_stall  output  1  freeze the pipeline while a D-miss is pending or in service.
- mem_en  output  1  one memory read request this cycle.
- mem_addr  output  ADDR_W  word-aligned request address.
- mem_data_valid  input  1  mem_data holds a returned word.
- mem_data  input  16  returned word.
- fill_we  output  1  write fill_data into the selected cache data array.
- fill_sel_d  output  1  0 = I-cache is the fill target, 1 = D-cache.
- fill_addr  output  ADDR_W  byte address of the word being written.
- fill_data  output  16  mem_data passed through.
- tag_we  output  1  write tag/valid for fill_addr's block (same cycle as last word).
- i_fill_done  output  1  one-cycle pulse; I block is now valid.
- d_fill_done  output  1  one-cycle pulse; D block is now valid.

Behaviour:
- States: IDLE, FILL, DONE.
- Reset: state=IDLE, counters=0.
  - All outputs 0; mem_addr, fill_addr and fill_data are 0.
  - Reset mid-fill aborts: no further fill_we/tag_we, no done pulse.
  - mem_data_valid arriving in IDLE or DONE is ignored.
- IDLE: if d_miss, latch d block (addr[15:4]) and set sel=1; else if i_miss, latch i block and set sel=0. Then go to FILL.
  - D has priority on a simultaneous miss; I is served next.
- FILL, issue side: 3-bit issue counter k = 0..7.
  - mem_en=1 for 8 consecutive cycles.
  - mem_addr = {block, k, 1'b0}.
  - Counter stops after k=7; mem_en=0 thereafter.
- FILL, receive side: 3-bit receive counter r increments on each mem_data_valid.
  - fill_we = mem_data_valid; fill_addr = {block, r, 1'b0}; fill_data = mem_data (combinational, same cycle).
  - Valid on r=7: tag_we=1, then go to DONE.
- DONE (one cycle): pulse the selected *_fill_done, then go to IDLE.
  - A miss for the same block is re-presented as a hit by the cache the following cycle.
- Latency: first miss cycle to done pulse is 1 + 7 + MEM_LATENCY + 1 = 13 cycles with defaults.
- Stalls:
  - i_stall = i_miss | (state!=IDLE & sel==0).
  - d_stall = d_miss | (state!=IDLE & sel==1).
  - Both are combinational.
- Deassertion of a miss during FILL is ignored; the fill always completes.
- A new miss arriving during FILL waits in IDLE arbitration.
- Counters wrap modulo WORDS_PER_BLOCK; no overflow out of the block.

Optional Feature:
- Macro CRITICAL_WORD_FIRST_EN.
- Defined:
  - Issue and receive counters start at the missed word offset w = miss_addr[3:1] and wrap modulo 8.
  - Example, w=6: order 6,7,0,...,5.
  - Termination is on the 8th received word, not on r=7.
  - Also adds output crit_word_valid, a 1-cycle pulse with the first fill_we, so the pipeline can consume the missed word early; stalls are unchanged.
- Undefined: order is always 0..7; crit_word_valid is absent.

Decomposition:
- Package cache_pkg holds:
  - fill_state_t enum {IDLE, FILL, DONE};
  - BLOCK_OFFSET_W=4, WORD_IDX_W=3;
  - FILL_SEL_I=0, FILL_SEL_D=1.
- One natural sub-module: fill_word_counter.
  - Loadable 3-bit wrap counter with enable and a "count of 8 done" flag.
  - Instantiated twice, for issue and receive.

Test Plan:
- i_miss=1, i_miss_addr=16'h0046, MEM_LATENCY=4 -> mem_addr 0x0040..0x004E on 8 consecutive cycles; fill_we on cycles 5..12 with matching fill_addr; tag_we on cycle 12; i_fill_done on 13; i_stall low on 14.
- i_miss and d_miss rise in the same cycle (d_addr 0x1230, i_addr 0x0200) -> D filled first (fill_sel_d=1, block 0x1230); then I fill (block 0x0200); i_stall high throughout.
- rst asserted mid-FILL after 3 returns -> all outputs 0 immediately; later mem_data_valid pulses cause no fill_we/tag_we.
- i_miss dropped mid-fill -> fill still completes; i_fill_done still pulses.
- CRITICAL_WORD_FIRST_EN, d_miss_addr=16'h00AC -> mem_addr order 0xAC,0xAE,0xA0,...,0xAA; crit_word_valid with the first fill_we (fill_addr 0xAC); tag_we on the 8th word.
- mem_data_valid pulsed while IDLE -> no fill_we, no state change.
